// File: rtl/regarb_pkg.sv
// Shared constants and request type for the register-bank write arbiter.
// Consumed by regfile_write_arbiter, its interface and regarb_scoreboard.
package regarb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int NUM_REGS   = 16;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  // 'reg' is a reserved word, so the destination field is reg_addr.
  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] reg_addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_req_t;

endpackage : regarb_pkg

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request, reservation and register-bank signals of the write arbiter.
// Handshake: a transfer completes when xValid && xReady at a rising clock edge.
interface regfile_write_arbiter_if
  import regarb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  localparam int NREGS = 1 << ADDR_W;

  logic              AluValid;
  logic [ADDR_W-1:0] AluReg;
  logic [DATA_W-1:0] AluData;
  logic              AluReady;

  logic              MemValid;
  logic [ADDR_W-1:0] MemReg;
  logic [DATA_W-1:0] MemData;
  logic              MemReady;

  logic              ReserveValid;
  logic [ADDR_W-1:0] ReserveReg;

  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [NREGS-1:0]  Busy;

  modport master (
    output AluValid, AluReg, AluData,
    output MemValid, MemReg, MemData,
    output ReserveValid, ReserveReg,
    input  AluReady, MemReady,
    input  RegWrite, WriteRegister, WriteData, Busy
  );

  modport slave (
    input  AluValid, AluReg, AluData,
    input  MemValid, MemReg, MemData,
    input  ReserveValid, ReserveReg,
    output AluReady, MemReady,
    output RegWrite, WriteRegister, WriteData, Busy
  );

endinterface : regfile_write_arbiter_if

// File: rtl/regarb_scoreboard.sv
// Pending-write bit per register: reservations set, accepted writebacks clear,
// a same-cycle set beats a clear; register 0 is never marked busy.
module regarb_scoreboard
  import regarb_pkg::*;
#(
  parameter  int ADDR_W = DEF_ADDR_W,
  localparam int NREGS  = 1 << ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_reg,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_reg,
  output logic [NREGS-1:0]  o_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_next;

  always_comb begin
    w_busy_next = r_busy;
    if (i_clr_en) begin
      w_busy_next[i_clr_reg] = 1'b0;
    end
    if (i_set_en) begin
      w_busy_next[i_set_reg] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign o_busy = r_busy;

endmodule : regarb_scoreboard

// File: rtl/regfile_write_arbiter.sv
// Shares the register bank write port between ALU and load writeback.
// REGARB_ROUND_ROBIN_EN selects round-robin; otherwise MEM wins every contention.
module regfile_write_arbiter
  import regarb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic                     clock,
  input logic                     reset_n,
  regfile_write_arbiter_if.slave  bus
);

  localparam int NREGS = 1 << ADDR_W;

  wb_req_t w_alu_req;
  wb_req_t w_mem_req;
  wb_req_t w_win_req;

  logic w_alu_ready;
  logic w_mem_ready;
  logic w_fire;

  logic              r_reg_write;
  logic [ADDR_W-1:0] r_write_register;
  logic [DATA_W-1:0] r_write_data;
  logic [NREGS-1:0]  w_busy;

  always_comb begin
    w_alu_req          = '0;
    w_alu_req.valid    = bus.AluValid;
    w_alu_req.reg_addr = bus.AluReg;
    w_alu_req.data     = bus.AluData;
    w_mem_req          = '0;
    w_mem_req.valid    = bus.MemValid;
    w_mem_req.reg_addr = bus.MemReg;
    w_mem_req.data     = bus.MemData;
  end

`ifdef REGARB_ROUND_ROBIN_EN
  logic r_last_gnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_last_gnt <= REQ_MEM;
    end else if (w_fire) begin
      r_last_gnt <= w_mem_ready ? REQ_MEM : REQ_ALU;
    end
  end
`endif

  // Ready depends only on the valids and the pointer, never on ReserveValid.
  always_comb begin
    w_alu_ready = 1'b0;
    w_mem_ready = 1'b0;
    if (reset_n) begin
      if (w_alu_req.valid && w_mem_req.valid) begin
`ifdef REGARB_ROUND_ROBIN_EN
        if (r_last_gnt == REQ_ALU) begin
          w_mem_ready = 1'b1;
        end else begin
          w_alu_ready = 1'b1;
        end
`else
        w_mem_ready = 1'b1;
`endif
      end else begin
        w_alu_ready = w_alu_req.valid;
        w_mem_ready = w_mem_req.valid;
      end
    end
  end

  always_comb begin
    w_win_req       = w_mem_ready ? w_mem_req : w_alu_req;
    w_win_req.valid = w_alu_ready | w_mem_ready;
  end

  assign w_fire = w_win_req.valid;

  // Writes to r0 complete the handshake but never reach the bank.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_reg_write      <= 1'b0;
      r_write_register <= '0;
      r_write_data     <= '0;
    end else begin
      r_reg_write <= w_fire && (w_win_req.reg_addr != '0);
      if (w_fire && (w_win_req.reg_addr != '0)) begin
        r_write_register <= w_win_req.reg_addr;
        r_write_data     <= w_win_req.data;
      end
    end
  end

  regarb_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_set_en  (bus.ReserveValid),
    .i_set_reg (bus.ReserveReg),
    .i_clr_en  (w_fire),
    .i_clr_reg (w_win_req.reg_addr),
    .o_busy    (w_busy)
  );

  assign bus.AluReady      = w_alu_ready;
  assign bus.MemReady      = w_mem_ready;
  assign bus.RegWrite      = r_reg_write;
  assign bus.WriteRegister = r_write_register;
  assign bus.WriteData     = r_write_data;
  assign bus.Busy          = w_busy;

endmodule : regfile_write_arbiter
